opamp_trim_sar: RTL and testbench
=================================

# opamp_trim_sar

Digital offset-trim calibration controller for a bank of on-chip two-stage op-amps. It sequences an auto-zero calibration across `NUM_CH` channels through one shared offset comparator. Each channel's `TRIM_W`-bit trim DAC code is resolved by successive approximation, and per-channel codes are held for the analog macro. It sits between the Tiny Tapeout digital pins and the analog op-amp array. Codes can also be loaded manually from the pins.

## Interface

Parameters:
- `NUM_CH`, 4: number of op-amp channels (≥1).
- `TRIM_W`, 6: trim DAC bits per channel (≥2).
- `SETTLE_CYC`, 16: settle cycles after each trial code before the comparator is sampled (≥1).
- `CH_W`, `$clog2(NUM_CH)` (min 1): channel index width (derived).

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `ena` in 1: block enable. Low aborts calibration and blocks `start`.
- `start` in 1: calibration request. Sampled only in IDLE with `ena`=1.
- `cmp_in` in 1: shared comparator output for channel `ch_sel`. 1 means the trial code is too high.
- `wr_en` in 1: manual trim write strobe.
- `wr_ch` in CH_W: manual write channel.
- `wr_data` in TRIM_W: manual write code.
- `trim_out` out NUM_CH*TRIM_W: channel k's code occupies bits [k*TRIM_W +: TRIM_W].
- `ch_sel` out CH_W: channel routed to the comparator.
- `az_en` out 1: auto-zero switch enable, shorting the inputs of the channel under calibration.
- `busy` out 1: calibration in progress.
- `done` out 1: one-cycle pulse on completion.
- `sat` out NUM_CH: per-channel flag, set when the final code is 0 or all-ones.

## Operation

- States: IDLE, SETTLE, DECIDE, NEXT_CH, DONE.
- IDLE → SETTLE on `start`=1 and `ena`=1.
  - Sets `ch`=0, `bit`=TRIM_W-1.
  - Loads channel 0 trim = MSB-only (1<<(TRIM_W-1)).
  - Clears all `sat` bits.
- SETTLE lasts exactly SETTLE_CYC cycles, counted by an internal counter, then goes to DECIDE.
- DECIDE (1 cycle) samples `cmp_in`.
  - If `cmp_in`=1, clear trim[ch][bit].
  - If bit>0: set trim[ch][bit-1], bit--, go to SETTLE.
  - If bit=0: go to NEXT_CH.
- NEXT_CH (1 cycle) sets `sat[ch]` if the final code is 0 or 2^TRIM_W-1.
  - If ch=NUM_CH-1: go to DONE.
  - Otherwise: ch++, bit=TRIM_W-1, load trim[ch]=MSB-only, go to SETTLE.
- DONE (1 cycle) asserts `done`=1, then goes to IDLE.
- Trial codes drive `trim_out` live. The active channel's trim register is the SAR register.
- `ch_sel` = ch in every state except IDLE, where it holds its last value.
- `busy`=1 in SETTLE, DECIDE and NEXT_CH.
- `az_en`=1 in SETTLE, DECIDE and NEXT_CH, and 0 in IDLE and DONE.
- Manual write: `wr_en`=1 in IDLE loads trim[wr_ch]=wr_data on the next edge.
  - Ignored in any other state.
  - Ignored if wr_ch ≥ NUM_CH.
  - Works regardless of `ena`.
  - Does not touch `sat`.
- `start` is ignored outside IDLE.
- Abort: `ena`=0 in any non-IDLE state → IDLE on the next edge.
  - The active channel's trim is set to MSB-only.
  - Completed channels keep their codes.
  - `done` is not pulsed and `sat` is not updated for the active channel.
- `sat` bits hold until the next accepted `start` or reset.

## Timing

- Reset (`rst_n`=0 at an edge) dominates everything, including mid-calibration. After the edge:
  - every trim = 1<<(TRIM_W-1);
  - `ch_sel`=0, `busy`=0, `az_en`=0, `done`=0, `sat`=0;
  - state IDLE.
- All outputs are registered. No combinational path from inputs to outputs.
- Calibration start (edge 0 is the one that samples `start`=1):
  - `busy`, `az_en` and the channel 0 trial code appear after edge 0.
  - `cmp_in` is sampled at edge 0 + SETTLE_CYC + 1 (the DECIDE cycle), then every SETTLE_CYC+1 cycles.
- Per channel: TRIM_W*(SETTLE_CYC+1)+1 cycles.
- `done` is high during the cycle after edge NUM_CH*(TRIM_W*(SETTLE_CYC+1)+1)+1.
  - With defaults: 413.
  - `busy` falls on the same edge `done` rises.
- A `start` held high at the DONE→IDLE edge is not accepted that cycle. Re-acceptance is no earlier than the cycle after `done`.
- A write in the same cycle as an accepted `start` is ignored. `start` wins.

## Test plan

- Reset check:
  - Stimulus: drive `rst_n`=0 for 2 cycles, then release.
  - Required: `trim_out`=0x820820 (4×6'b100000), `busy`=`az_en`=`done`=`sat`=0, `ch_sel`=0.
- Full calibration:
  - Stimulus: comparator model `cmp_in`=(trim[ch_sel] > target[ch_sel]) with targets {13, 40, 1, 62}; pulse `start`.
  - Required: `done` at cycle 413, final codes {13, 40, 1, 62}, `sat`=0, `az_en` low after done.
- Saturation:
  - Stimulus: targets {0, 63, 32, 31}.
  - Required: codes {0, 63, 32, 31}, `sat`=4'b0011.
- Abort:
  - Stimulus: drop `ena` during channel 2's SETTLE.
  - Required: IDLE next edge, `busy`=0, no `done`, channels 0–1 keep their codes, channel 2 = 32, channel 3 unchanged.
- Manual write and busy guard:
  - Stimulus: in IDLE, write ch1=0x2A; then during calibration write ch3=0x05 and pulse `start` again.
  - Required: ch1=0x2A before calibration, the busy-time write and restart both ignored, `done` still at cycle 413.
- Reset mid-calibration:
  - Stimulus: assert `rst_n`=0 at cycle 200.
  - Required: all reset values next edge, no `done` pulse afterward.

Source files
------------

// File: rtl/opamp_trim_sar.sv
// Offset-trim calibration controller: resolves one trim DAC code per op-amp channel
// by successive approximation through a shared comparator, with manual code loading.
module opamp_trim_sar #(
  parameter int NUM_CH     = 4,
  parameter int TRIM_W     = 6,
  parameter int SETTLE_CYC = 16,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       start,
  input  logic                       cmp_in,
  input  logic                       wr_en,
  input  logic [CH_W-1:0]            wr_ch,
  input  logic [TRIM_W-1:0]          wr_data,
  output logic [NUM_CH*TRIM_W-1:0]   trim_out,
  output logic [CH_W-1:0]            ch_sel,
  output logic                       az_en,
  output logic                       busy,
  output logic                       done,
  output logic [NUM_CH-1:0]          sat
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_DECIDE = 3'd2;
  localparam logic [2:0] S_NEXT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int BIT_W = $clog2(TRIM_W);
  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [TRIM_W-1:0] MSB_CODE  = {1'b1, {(TRIM_W-1){1'b0}}};
  localparam logic [TRIM_W-1:0] ZERO_CODE = {TRIM_W{1'b0}};
  localparam logic [TRIM_W-1:0] FULL_CODE = {TRIM_W{1'b1}};
  localparam logic [BIT_W-1:0]  TOP_BIT   = BIT_W'(TRIM_W - 1);
  localparam logic [BIT_W-1:0]  BIT_ZERO  = {BIT_W{1'b0}};
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);
  localparam logic [CH_W-1:0]   CH_ZERO   = {CH_W{1'b0}};
  localparam logic [CH_W:0]     NUM_CH_L  = (CH_W + 1)'(NUM_CH);

  logic [2:0]        state_r;
  logic [2:0]        state_n_s;
  logic [CH_W-1:0]   ch_r;
  logic [CH_W-1:0]   ch_n_s;
  logic [BIT_W-1:0]  bit_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [TRIM_W-1:0] trim_r [NUM_CH];
  logic [NUM_CH-1:0] sat_r;
  logic              done_r;
  logic              busy_r;
  logic              az_en_r;
  logic [CH_W-1:0]   ch_sel_r;

  logic start_ok_s;
  logic abort_s;
  logic wr_ok_s;
  logic last_ch_s;

  function automatic logic is_active(input logic [2:0] s);
    return (s == S_SETTLE) || (s == S_DECIDE) || (s == S_NEXT);
  endfunction

  function automatic logic is_sat_code(input logic [TRIM_W-1:0] c);
    return (c == ZERO_CODE) || (c == FULL_CODE);
  endfunction

  // Request qualification; a start in the same cycle as a write wins.
  always_comb begin
    start_ok_s = (state_r == S_IDLE) && ena && start;
    abort_s    = (state_r != S_IDLE) && !ena;
    wr_ok_s    = (state_r == S_IDLE) && wr_en && !start_ok_s && ({1'b0, wr_ch} < NUM_CH_L);
    last_ch_s  = (ch_r == LAST_CH);
  end

  // Next-state and next-channel selection.
  always_comb begin
    state_n_s = state_r;
    ch_n_s    = ch_r;
    if (abort_s) begin
      state_n_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start_ok_s) begin
            state_n_s = S_SETTLE;
            ch_n_s    = CH_ZERO;
          end else begin
            state_n_s = S_IDLE;
          end
        end
        S_SETTLE: state_n_s = (cnt_r == LAST_CNT) ? S_DECIDE : S_SETTLE;
        S_DECIDE: state_n_s = (bit_r == BIT_ZERO) ? S_NEXT : S_SETTLE;
        S_NEXT: begin
          if (last_ch_s) begin
            state_n_s = S_DONE;
          end else begin
            state_n_s = S_SETTLE;
            ch_n_s    = ch_r + CH_W'(1);
          end
        end
        S_DONE:  state_n_s = S_IDLE;
        default: state_n_s = S_IDLE;
      endcase
    end
  end

  // Sequencer, SAR datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      ch_r     <= CH_ZERO;
      bit_r    <= BIT_ZERO;
      cnt_r    <= CNT_ZERO;
      sat_r    <= {NUM_CH{1'b0}};
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
      az_en_r  <= 1'b0;
      ch_sel_r <= CH_ZERO;
      for (int k = 0; k < NUM_CH; k++) trim_r[k] <= MSB_CODE;
    end else begin
      state_r <= state_n_s;
      ch_r    <= ch_n_s;
      cnt_r   <= ((state_r == S_SETTLE) && (state_n_s == S_SETTLE)) ? cnt_r + CNT_W'(1) : CNT_ZERO;
      // done lags the DONE state by one edge; busy stays up through DONE so both change together
      done_r  <= (state_r == S_DONE) && ena;
      busy_r  <= is_active(state_n_s) || (state_n_s == S_DONE);
      az_en_r <= is_active(state_n_s);
      if (state_n_s != S_IDLE) ch_sel_r <= ch_n_s;

      if (abort_s) begin
        if (is_active(state_r)) trim_r[ch_r] <= MSB_CODE;
      end else begin
        case (state_r)
          S_IDLE: begin
            if (start_ok_s) begin
              bit_r     <= TOP_BIT;
              trim_r[0] <= MSB_CODE;
              sat_r     <= {NUM_CH{1'b0}};
            end else if (wr_ok_s) begin
              trim_r[wr_ch] <= wr_data;
            end
          end
          S_DECIDE: begin
            if (cmp_in) trim_r[ch_r][bit_r] <= 1'b0;
            if (bit_r != BIT_ZERO) begin
              trim_r[ch_r][bit_r - BIT_W'(1)] <= 1'b1;
              bit_r <= bit_r - BIT_W'(1);
            end
          end
          S_NEXT: begin
            if (is_sat_code(trim_r[ch_r])) sat_r[ch_r] <= 1'b1;
            if (!last_ch_s) begin
              bit_r          <= TOP_BIT;
              trim_r[ch_n_s] <= MSB_CODE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_trim_out
    assign trim_out[g*TRIM_W +: TRIM_W] = trim_r[g];
  end

  assign ch_sel = ch_sel_r;
  assign az_en  = az_en_r;
  assign busy   = busy_r;
  assign done   = done_r;
  assign sat    = sat_r;

endmodule

// File: tb/tb_opamp_trim_sar.sv
// Directed bench for opamp_trim_sar: vector table of comparator targets plus
// hand-written abort, busy-guard and mid-calibration reset sequences.
module tb_opamp_trim_sar;

  localparam int DONE_CYC = 413;

  logic        clk = 1'b0;
  logic        rst_n, ena, start, cmp_in, wr_en;
  logic [1:0]  wr_ch;
  logic [5:0]  wr_data;
  logic [23:0] trim_out;
  logic [1:0]  ch_sel;
  logic        az_en, busy, done;
  logic [3:0]  sat;

  logic [23:0] tgt;
  logic [5:0]  cur;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [23:0] tgt;
    logic [23:0] code;
    logic [3:0]  sat;
  } vec_t;

  vec_t vecs [3];

  opamp_trim_sar dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .cmp_in(cmp_in),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data), .trim_out(trim_out),
    .ch_sel(ch_sel), .az_en(az_en), .busy(busy), .done(done), .sat(sat)
  );

  always #5 clk = ~clk;

  // Comparator model: high when the routed channel's trial code exceeds its target.
  always_comb begin
    cur    = trim_out[int'(ch_sel)*6 +: 6];
    cmp_in = (cur > tgt[int'(ch_sel)*6 +: 6]);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cal(input logic [23:0] t);
    tgt   = t;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs until done or a cycle budget; optionally pokes a write and restart mid-run.
  task automatic wait_done(input bit poke, output int n);
    n = 0;
    while (done !== 1'b1 && n < 1000) begin
      if (poke && n == 50) begin
        wr_en = 1'b1; wr_ch = 2'd3; wr_data = 6'h05; start = 1'b1;
      end
      tick();
      n++;
      wr_en = 1'b0; start = 1'b0;
    end
  endtask

  task automatic run_no_done(input int cycles, output int seen);
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (done === 1'b1) seen++;
    end
  endtask

  initial begin
    int n;
    int seen;

    vecs[0] = '{tgt: {6'd62, 6'd1,  6'd40, 6'd13}, code: {6'd62, 6'd1,  6'd40, 6'd13}, sat: 4'b0000};
    vecs[1] = '{tgt: {6'd31, 6'd32, 6'd63, 6'd0},  code: {6'd31, 6'd32, 6'd63, 6'd0},  sat: 4'b0011};
    vecs[2] = '{tgt: {6'd7,  6'd0,  6'd63, 6'd21}, code: {6'd7,  6'd0,  6'd63, 6'd21}, sat: 4'b0110};

    rst_n = 1'b0; ena = 1'b1; start = 1'b0; wr_en = 1'b0; wr_ch = 2'd0; wr_data = 6'd0;
    tgt = 24'h0;
    tick(); tick();
    rst_n = 1'b1;
    chk("reset_trim",   32'(trim_out), 32'h820820);
    chk("reset_busy",   32'(busy),     32'h0);
    chk("reset_az_en",  32'(az_en),    32'h0);
    chk("reset_done",   32'(done),     32'h0);
    chk("reset_sat",    32'(sat),      32'h0);
    chk("reset_ch_sel", 32'(ch_sel),   32'h0);

    wr_en = 1'b1; wr_ch = 2'd1; wr_data = 6'h2A;
    tick();
    wr_en = 1'b0;
    chk("idle_write", 32'(trim_out), 32'({6'd32, 6'd32, 6'h2A, 6'd32}));

    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        wr_en = 1'b1; wr_ch = 2'd1; wr_data = 6'h11;
      end
      start_cal(vecs[i].tgt);
      wr_en = 1'b0;
      if (i == 0) chk("start_beats_write", 32'(trim_out[11:6]), 32'h2A);
      chk("start_busy",  32'(busy),          32'h1);
      chk("start_az_en", 32'(az_en),         32'h1);
      chk("start_trial", 32'(trim_out[5:0]), 32'h20);
      wait_done(i == 0, n);
      chk("done_cycle", 32'(n),        32'(DONE_CYC));
      chk("done_busy",  32'(busy),     32'h0);
      chk("done_az_en", 32'(az_en),    32'h0);
      chk("final_code", 32'(trim_out), 32'(vecs[i].code));
      chk("final_sat",  32'(sat),      32'(vecs[i].sat));
      tick();
      chk("done_pulse_width", 32'(done), 32'h0);
    end

    // Abort during channel 2 settle; codes before are {7,0,63,21}.
    start_cal(vecs[0].tgt);
    n = 0;
    while (n < 210) begin
      tick();
      n++;
    end
    chk("abort_pre_ch_sel", 32'(ch_sel), 32'h2);
    chk("abort_pre_busy",   32'(busy),   32'h1);
    ena = 1'b0;
    tick();
    chk("abort_busy",  32'(busy),     32'h0);
    chk("abort_az_en", 32'(az_en),    32'h0);
    chk("abort_trim",  32'(trim_out), 32'({6'd7, 6'd32, 6'd40, 6'd13}));
    run_no_done(420, seen);
    chk("abort_no_done", 32'(seen), 32'h0);
    ena = 1'b1;

    // Reset mid-calibration.
    start_cal(vecs[0].tgt);
    for (int c = 0; c < 200; c++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_trim",   32'(trim_out), 32'h820820);
    chk("midrst_busy",   32'(busy),     32'h0);
    chk("midrst_az_en",  32'(az_en),    32'h0);
    chk("midrst_sat",    32'(sat),      32'h0);
    chk("midrst_ch_sel", 32'(ch_sel),   32'h0);
    run_no_done(450, seen);
    chk("midrst_no_done", 32'(seen), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
